// File: rtl/snes_reader_if.sv
`default_nettype none
// ============================================================================
// Module      : snes_reader_if
// Description : Bundles the pad-side lines and the decoded-button outputs of
//               the SNES game-pad reader into one interface.
//               master : the reader (drives latch/clk and the decoded word)
//               slave  : the pad and downstream consumer
//   snes_serial : raw controller data line, active-low (pad -> reader)
//   snes_latch  : controller latch strobe, active-high
//   snes_clk    : controller shift clock, idles high
//   snes_data   : 12 decoded buttons, 1 = pressed
//   data_valid  : one-cycle pulse when snes_data is updated
//   present     : controller-detected flag
// Revision    : 1.0 - initial release
// ============================================================================
interface snes_reader_if;
  logic        snes_serial;
  logic        snes_latch;
  logic        snes_clk;
  logic [11:0] snes_data;
  logic        data_valid;
  logic        present;

  modport master (
    input  snes_serial,
    output snes_latch, snes_clk, snes_data, data_valid, present
  );

  modport slave (
    output snes_serial,
    input  snes_latch, snes_clk, snes_data, data_valid, present
  );
endinterface
`default_nettype wire

// File: rtl/snes_reader.sv
`default_nettype none
// ============================================================================
// Module      : snes_reader
// Description : Serial front end for the SNES game-pad port. Polls the pad
//               every POLL_DIV cycles, drives latch/shift-clock, shifts in the
//               16-bit active-low stream and publishes 12 active-high buttons.
//   clk    : system clock
//   reset  : synchronous, active-high reset
//   bus    : snes_reader_if.master (snes_serial in; snes_latch, snes_clk,
//            snes_data[11:0], data_valid, present out)
// Parameters  : CLK_DIV  - clk cycles per SNES half-bit (>= 4)
//               POLL_DIV - clk cycles spent idle between transactions
// Macro       : SNES_CONNECT_CHECK_EN - when defined, the trailing ID bits
//               (raw[15:12]) must all read released for the pad to count as
//               present; otherwise present is tied high.
// Revision    : 1.0 - initial release
// ============================================================================
module snes_reader #(
  parameter int CLK_DIV  = 300,
  parameter int POLL_DIV = 833333
) (
  input  wire          clk,
  input  wire          reset,
  snes_reader_if.master bus
);

  localparam int c_DIV_W  = $clog2(2 * CLK_DIV);
  localparam int c_POLL_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;

  localparam logic [c_POLL_W-1:0] c_POLL_LAST  = c_POLL_W'(POLL_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_HALF_LAST  = c_DIV_W'(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_LOW_FIRST  = c_DIV_W'(CLK_DIV);
  localparam logic [c_DIV_W-1:0]  c_BIT_LAST   = c_DIV_W'(2 * CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LATCH = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              r_state, w_state_next;
  logic [c_POLL_W-1:0] r_poll_cnt, w_poll_next;
  logic [c_DIV_W-1:0]  r_div_cnt, w_div_next;
  logic [3:0]          r_bit_idx, w_idx_next;
  logic [15:0]         r_raw, w_raw_next;
  logic [1:0]          r_sync;
  logic                r_snes_latch, w_latch_next;
  logic                r_snes_clk, w_sclk_next;
  logic [11:0]         r_snes_data, w_data_next;
  logic                r_data_valid, w_valid_next;
`ifdef SNES_CONNECT_CHECK_EN
  logic                r_present, w_present_next;
`endif

  // Two-flop synchronizer for the asynchronous pad line; resets to the
  // released (high) level.
  always_ff @(posedge clk) begin
    if (reset) r_sync <= 2'b11;
    else       r_sync <= {r_sync[0], bus.snes_serial};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_poll_cnt   <= '0;
      r_div_cnt    <= '0;
      r_bit_idx    <= '0;
      r_raw        <= '0;
      r_snes_latch <= 1'b0;
      r_snes_clk   <= 1'b1;
      r_snes_data  <= '0;
      r_data_valid <= 1'b0;
`ifdef SNES_CONNECT_CHECK_EN
      r_present    <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_next;
      r_poll_cnt   <= w_poll_next;
      r_div_cnt    <= w_div_next;
      r_bit_idx    <= w_idx_next;
      r_raw        <= w_raw_next;
      r_snes_latch <= w_latch_next;
      r_snes_clk   <= w_sclk_next;
      r_snes_data  <= w_data_next;
      r_data_valid <= w_valid_next;
`ifdef SNES_CONNECT_CHECK_EN
      r_present    <= w_present_next;
`endif
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_poll_next  = '0;
    w_div_next   = '0;
    w_idx_next   = r_bit_idx;
    w_raw_next   = r_raw;
    w_data_next  = r_snes_data;
    w_valid_next = 1'b0;
`ifdef SNES_CONNECT_CHECK_EN
    w_present_next = r_present;
`endif

    case (r_state)
      S_IDLE: begin
        if (r_poll_cnt == c_POLL_LAST) w_state_next = S_LATCH;
        else                           w_poll_next  = r_poll_cnt + 1'b1;
      end

      S_LATCH: begin
        if (r_div_cnt == c_BIT_LAST) begin
          w_state_next = S_SHIFT;
          w_idx_next   = '0;
        end else begin
          w_div_next = r_div_cnt + 1'b1;
        end
      end

      S_SHIFT: begin
        // Sample late in the high half so the synchronizer delay is absorbed.
        if (r_div_cnt == c_HALF_LAST) w_raw_next[r_bit_idx] = r_sync[1];
        if (r_div_cnt == c_BIT_LAST) begin
          if (r_bit_idx == 4'd15) begin
            // raw is complete here: bit 15 was sampled in its high half.
            w_state_next = S_DONE;
            w_valid_next = 1'b1;
`ifdef SNES_CONNECT_CHECK_EN
            w_present_next = &r_raw[15:12];
            w_data_next    = (&r_raw[15:12]) ? ~r_raw[11:0] : 12'h000;
`else
            w_data_next    = ~r_raw[11:0];
`endif
          end else begin
            w_idx_next = r_bit_idx + 1'b1;
          end
        end else begin
          w_div_next = r_div_cnt + 1'b1;
        end
      end

      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase

    // Pad-facing lines are registered from the next state so they leave the
    // chip glitch-free and aligned with the state register.
    w_latch_next = (w_state_next == S_LATCH);
    w_sclk_next  = !((w_state_next == S_SHIFT) && (w_div_next >= c_LOW_FIRST));
  end

  assign bus.snes_latch = r_snes_latch;
  assign bus.snes_clk   = r_snes_clk;
  assign bus.snes_data  = r_snes_data;
  assign bus.data_valid = r_data_valid;
`ifdef SNES_CONNECT_CHECK_EN
  assign bus.present    = r_present;
`else
  assign bus.present    = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snes_reader.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_snes_reader
// Description : Self-checking bench for snes_reader with a behavioural pad
//               model and a queue of expected words.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_snes_reader;

  localparam int CD          = 4;
  localparam int PD          = 16;
  localparam int PERIOD      = PD + 34 * CD + 1;
  localparam int FIRST_VALID = PD + 34 * CD;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  snes_reader_if bus ();

  snes_reader #(.CLK_DIV(CD), .POLL_DIV(PD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.master)
  );

  // Pad model: line level is live (not latched) so mid-frame changes are
  // visible; latch restarts at bit 0, each rising shift clock advances.
  logic [15:0] pad_line = 16'hFFFF;
  int          pad_idx  = 16;
  always @(posedge bus.snes_latch) pad_idx = 0;
  always @(posedge bus.snes_clk) if (!bus.snes_latch && pad_idx < 16) pad_idx = pad_idx + 1;
  assign bus.snes_serial = (pad_idx < 16) ? pad_line[pad_idx[3:0]] : 1'b1;

  typedef struct packed {
    logic [11:0] data;
    logic        present;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  function automatic exp_t model(input logic [15:0] line);
    exp_t e;
`ifdef SNES_CONNECT_CHECK_EN
    e.present = (line[15:12] == 4'hF);
    e.data    = e.present ? ~line[11:0] : 12'h000;
`else
    e.present = 1'b1;
    e.data    = ~line[11:0];
`endif
    return e;
  endfunction

  // Bounded wait for data_valid; also reports whether snes_data stayed put.
  task automatic wait_valid(input int budget, output bit seen, output bit held);
    logic [11:0] start;
    int n;
    start = bus.snes_data;
    seen  = 1'b0;
    held  = 1'b1;
    n     = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      if (bus.data_valid) seen = 1'b1;
      else if (bus.snes_data !== start) held = 1'b0;
    end
  endtask

  task automatic test_reset();
    logic exp_present;
`ifdef SNES_CONNECT_CHECK_EN
    exp_present = 1'b0;
`else
    exp_present = 1'b1;
`endif
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (bus.snes_latch !== 1'b0) begin errors++; $display("FAIL reset_latch: got %b want 0", bus.snes_latch); end
    checks++; if (bus.snes_clk !== 1'b1) begin errors++; $display("FAIL reset_sclk: got %b want 1", bus.snes_clk); end
    checks++; if (bus.snes_data !== 12'h000) begin errors++; $display("FAIL reset_data: got %h want 000", bus.snes_data); end
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", bus.data_valid); end
    checks++; if (bus.present !== exp_present) begin errors++; $display("FAIL reset_present: got %b want %b", bus.present, exp_present); end
  endtask

  task automatic test_timing();
    int c0, latch_rise, latch_hi, pulses, low_len, bad_len, valid_at;
    logic prev_latch, prev_clk;
    exp_t e;
    pad_line = 16'hFFFF;
    exp_q.push_back(model(pad_line));
    reset = 1'b0;
    c0 = cyc;
    latch_rise = -1; latch_hi = 0; pulses = 0; low_len = 0; bad_len = 0; valid_at = -1;
    prev_latch = bus.snes_latch;
    prev_clk   = bus.snes_clk;
    for (int i = 0; i < FIRST_VALID + 20 && valid_at < 0; i++) begin
      @(negedge clk);
      if (bus.snes_latch && !prev_latch && latch_rise < 0) latch_rise = cyc - c0;
      if (bus.snes_latch) latch_hi++;
      if (!bus.snes_clk) low_len++;
      if (bus.snes_clk && !prev_clk) begin
        pulses++;
        if (low_len != CD) bad_len++;
        low_len = 0;
      end
      if (bus.data_valid) valid_at = cyc - c0;
      prev_latch = bus.snes_latch;
      prev_clk   = bus.snes_clk;
    end
    e = exp_q.pop_front();
    checks++; if (latch_rise != PD) begin errors++; $display("FAIL latch_rise: got %0d want %0d", latch_rise, PD); end
    checks++; if (latch_hi != 2 * CD) begin errors++; $display("FAIL latch_width: got %0d want %0d", latch_hi, 2 * CD); end
    checks++; if (pulses != 16) begin errors++; $display("FAIL sclk_pulses: got %0d want 16", pulses); end
    checks++; if (bad_len != 0) begin errors++; $display("FAIL sclk_low_len: got %0d bad pulses want 0", bad_len); end
    checks++; if (valid_at != FIRST_VALID) begin errors++; $display("FAIL first_valid: got %0d want %0d", valid_at, FIRST_VALID); end
    checks++; if (bus.snes_data !== e.data) begin errors++; $display("FAIL timing_data: got %h want %h", bus.snes_data, e.data); end
    @(negedge clk);
    checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL valid_width: got %b want 0", bus.data_valid); end
  endtask

  task automatic test_buttons();
    logic [15:0] pats [4];
    bit seen, held;
    exp_t e;
    pats[0] = 16'hFEF7;   // A + Start pressed
    pats[1] = 16'hFFFF;   // nothing pressed
    pats[2] = 16'h0000;   // stuck-low line
    pats[3] = 16'hF5A3;
    for (int i = 0; i < 4; i++) begin
      pad_line = pats[i];
      exp_q.push_back(model(pad_line));
      wait_valid(PERIOD + 10, seen, held);
      e = exp_q.pop_front();
      checks++; if (!seen) begin errors++; $display("FAIL buttons_timeout[%0d]: got no valid want pulse", i); end
      checks++; if (bus.snes_data !== e.data || bus.present !== e.present)
        begin errors++; $display("FAIL buttons[%0d]: got %h/%b want %h/%b", i, bus.snes_data, bus.present, e.data, e.present); end
      @(negedge clk);
      checks++; if (bus.data_valid !== 1'b0) begin errors++; $display("FAIL buttons_valid_width[%0d]: got %b want 0", i, bus.data_valid); end
    end
  endtask

  task automatic test_mid_change();
    logic [15:0] a, b, merged;
    bit seen, held;
    int n;
    exp_t e;
    a = 16'hFAAA;
    b = 16'hF555;
    merged = (b & 16'hFFE0) | (a & 16'h001F);
    pad_line = a;
    exp_q.push_back(model(merged));
    n = 0;
    @(negedge clk);
    while (!(bus.snes_latch == 1'b0 && pad_idx == 5) && n < PERIOD + 10) begin @(negedge clk); n++; end
    pad_line = b;
    wait_valid(PERIOD + 10, seen, held);
    e = exp_q.pop_front();
    checks++; if (n >= PERIOD + 10 || !seen) begin errors++; $display("FAIL mid_timeout: got wait %0d seen %b want pulse", n, seen); end
    checks++; if (!held) begin errors++; $display("FAIL mid_hold: got data change before valid want stable"); end
    checks++; if (bus.snes_data !== e.data || bus.present !== e.present)
      begin errors++; $display("FAIL mid_data: got %h/%b want %h/%b", bus.snes_data, bus.present, e.data, e.present); end
    @(negedge clk);
  endtask

  task automatic test_reset_abort();
    logic exp_present;
    bit seen, held;
    int n, c0;
    exp_t e;
`ifdef SNES_CONNECT_CHECK_EN
    exp_present = 1'b0;
`else
    exp_present = 1'b1;
`endif
    pad_line = 16'hF3C5;
    n = 0;
    @(negedge clk);
    while (!(pad_idx == 9 && bus.snes_clk == 1'b0) && n < PERIOD + 10) begin @(negedge clk); n++; end
    reset = 1'b1;
    @(negedge clk);
    checks++; if (bus.snes_clk !== 1'b1 || bus.snes_latch !== 1'b0)
      begin errors++; $display("FAIL abort_lines: got clk %b latch %b want 1 0 (wait %0d)", bus.snes_clk, bus.snes_latch, n); end
    checks++; if (bus.snes_data !== 12'h000) begin errors++; $display("FAIL abort_data: got %h want 000", bus.snes_data); end
    checks++; if (bus.present !== exp_present) begin errors++; $display("FAIL abort_present: got %b want %b", bus.present, exp_present); end
    reset = 1'b0;
    c0 = cyc;
    n = 0;
    while (!bus.snes_latch && n < PD + 10) begin @(negedge clk); n++; end
    checks++; if (cyc - c0 != PD) begin errors++; $display("FAIL abort_relatch: got %0d want %0d", cyc - c0, PD); end
    exp_q.push_back(model(pad_line));
    wait_valid(PERIOD + 10, seen, held);
    e = exp_q.pop_front();
    checks++; if (!seen || bus.snes_data !== e.data || bus.present !== e.present)
      begin errors++; $display("FAIL abort_next_frame: got %h/%b seen %b want %h/%b", bus.snes_data, bus.present, seen, e.data, e.present); end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] pats [3];
    int t [3];
    bit seen, held;
    exp_t e;
    pats[0] = 16'hFF00;
    pats[1] = 16'hF0FF;
    pats[2] = 16'hFE7D;
    for (int i = 0; i < 3; i++) begin
      pad_line = pats[i];
      exp_q.push_back(model(pad_line));
      wait_valid(PERIOD + 10, seen, held);
      t[i] = cyc;
      e = exp_q.pop_front();
      checks++; if (!seen || bus.snes_data !== e.data || bus.present !== e.present)
        begin errors++; $display("FAIL b2b_data[%0d]: got %h/%b seen %b want %h/%b", i, bus.snes_data, bus.present, seen, e.data, e.present); end
      if (i > 0) begin
        checks++; if (t[i] - t[i-1] != PERIOD)
          begin errors++; $display("FAIL b2b_period[%0d]: got %0d want %0d", i, t[i] - t[i-1], PERIOD); end
      end
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got simulation still running want finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_timing();
    test_buttons();
    test_mid_change();
    test_reset_abort();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
